mul4_seq_ctrl: RTL and testbench

Sequencer that computes a wide unsigned product by time-multiplexing one shared 4x4 array multiplier (the combinational full-adder array already in the design) over nibble partial products. It sits between the instruction/operand path and the 4x4 multiplier. It owns the multiplier's `m`/`q` inputs, accumulates the shifted 8-bit partial products, and reports completion with a start/done handshake.

---
 rtl/mul4_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_mul4_seq_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mul4_seq_ctrl.sv
// mul4_seq_ctrl
// Computes an unsigned (4*NIB)x(4*NIB) product by stepping one shared 4x4
// combinational multiplier over every nibble pair. Each partial product is
// shifted into place and added to the accumulator. The result is reported
// with a start/done handshake.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             request, accepted when not busy (IDLE or DONE)
//   a, b              operands, latched on an accepted start
//   busy              high while partial products are accumulated
//   done              one-cycle pulse, product valid from this cycle
//   product           accumulator, held until the next accepted start
//   mul_m, mul_q      nibbles driven to the external 4x4 multiplier
//   mul_p             combinational product returned by that multiplier
module mul4_seq_ctrl #(
    parameter int NIB = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4*NIB-1:0] a,
    input  logic [4*NIB-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [8*NIB-1:0] product,
    output logic [3:0]       mul_m,
    output logic [3:0]       mul_q,
    input  logic [7:0]       mul_p
);

    localparam int OW = 4 * NIB;
    localparam int PW = 8 * NIB;
    localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   a_q, a_d, b_q, b_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   i_q, i_d, j_q, j_d;
    logic            busy_q, busy_d, done_q, done_d;

    logic [5:0]      nib_sh;
    logic [PW-1:0]   pp;
    logic            last_step;

    // Multiplier operands come straight from the counters so mul_p is
    // consumed in the same cycle it is produced.
    always_comb begin
        mul_m = '0;
        mul_q = '0;
        if (state_q == RUN) begin
            mul_m = a_q[4*i_q +: 4];
            mul_q = b_q[4*j_q +: 4];
        end
    end

    // Partial product weight is nibble position i+j; the zero-extended
    // 8-bit product always fits since the top position is 2*NIB-2.
    always_comb begin
        nib_sh    = 6'(i_q) + 6'(j_q);
        pp        = PW'(mul_p) << {nib_sh, 2'b00};
        last_step = (i_q == LAST) && (j_q == LAST);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_q + pp;
                if (last_step) begin
                    i_d     = '0;
                    j_d     = '0;
                    state_d = DONE;
                end else if (i_q == LAST) begin
                    i_d = '0;
                    j_d = j_q + CW'(1);
                end else begin
                    i_d = i_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            j_q     <= j_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: tb/tb_mul4_seq_ctrl.sv
// Bench for mul4_seq_ctrl: three instances (NIB=1,2,4) share one clock.
// The 4x4 multiplier is modelled here with plain arithmetic. Expected
// nibble order, timing and products come from a*b and simple loops.
module tb_mul4_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_s [3];
    logic [15:0] a_s [3];
    logic [15:0] b_s [3];

    wire        bz0, bz1, bz2, dn0, dn1, dn2;
    wire [7:0]  p0;
    wire [15:0] p1;
    wire [31:0] p2;
    wire [3:0]  m0, m1, m2, q0, q1, q2;
    wire [7:0]  mp0, mp1, mp2;

    assign mp0 = 8'(m0) * 8'(q0);
    assign mp1 = 8'(m1) * 8'(q1);
    assign mp2 = 8'(m2) * 8'(q2);

    mul4_seq_ctrl #(.NIB(1)) u_n1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .a(a_s[0][3:0]), .b(b_s[0][3:0]),
        .busy(bz0), .done(dn0), .product(p0), .mul_m(m0), .mul_q(q0), .mul_p(mp0));
    mul4_seq_ctrl #(.NIB(2)) u_n2 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .a(a_s[1][7:0]), .b(b_s[1][7:0]),
        .busy(bz1), .done(dn1), .product(p1), .mul_m(m1), .mul_q(q1), .mul_p(mp1));
    mul4_seq_ctrl #(.NIB(4)) u_n4 (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .a(a_s[2]), .b(b_s[2]),
        .busy(bz2), .done(dn2), .product(p2), .mul_m(m2), .mul_q(q2), .mul_p(mp2));

    int n_chk = 0;
    int n_err = 0;
    int nibv [3] = '{1, 2, 4};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic busy_of(input int k);
        case (k) 0: return bz0; 1: return bz1; default: return bz2; endcase
    endfunction
    function automatic logic done_of(input int k);
        case (k) 0: return dn0; 1: return dn1; default: return dn2; endcase
    endfunction
    function automatic logic [31:0] prod_of(input int k);
        case (k) 0: return 32'(p0); 1: return 32'(p1); default: return p2; endcase
    endfunction
    function automatic logic [3:0] mm_of(input int k);
        case (k) 0: return m0; 1: return m1; default: return m2; endcase
    endfunction
    function automatic logic [3:0] mq_of(input int k);
        case (k) 0: return q0; 1: return q1; default: return q2; endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One operation: start for one cycle, then walk the expected nibble
    // order (j outer, i inner) and finish with the done cycle. With noise,
    // operands and start are scrambled during RUN and must not matter.
    task automatic run_op(input int k, input logic [15:0] a_in, input logic [15:0] b_in, input bit noise);
        int n;
        logic [31:0] mask, a, b;
        n    = nibv[k];
        mask = (32'h1 << (4 * n)) - 32'h1;
        a    = 32'(a_in) & mask;
        b    = 32'(b_in) & mask;
        @(negedge clk);
        a_s[k] = a_in; b_s[k] = b_in; start_s[k] = 1'b1;
        tick();
        start_s[k] = 1'b0;
        for (int j = 0; j < n; j++) begin
            for (int i = 0; i < n; i++) begin
                chk("busy_run", 64'(busy_of(k)), 64'd1);
                chk("done_run", 64'(done_of(k)), 64'd0);
                chk("mul_m", 64'(mm_of(k)), 64'((a >> (4 * i)) & 32'hF));
                chk("mul_q", 64'(mq_of(k)), 64'((b >> (4 * j)) & 32'hF));
                if (noise) begin
                    a_s[k] = 16'($urandom); b_s[k] = 16'($urandom);
                    start_s[k] = 1'($urandom_range(0, 1));
                end
                tick();
            end
        end
        start_s[k] = 1'b0;
        chk("done", 64'(done_of(k)), 64'd1);
        chk("busy_done", 64'(busy_of(k)), 64'd0);
        chk("product", 64'(prod_of(k)), 64'(a) * 64'(b));
        chk("mul_m_off", 64'({mm_of(k), mq_of(k)}), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start_s[k] = 1'b0; a_s[k] = '0; b_s[k] = '0;
        end
        tick(); tick();
        for (int k = 0; k < 3; k++) begin
            chk("rst_busy", 64'(busy_of(k)), 64'd0);
            chk("rst_done", 64'(done_of(k)), 64'd0);
            chk("rst_product", 64'(prod_of(k)), 64'd0);
            chk("rst_mul", 64'({mm_of(k), mq_of(k)}), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        run_op(1, 16'hFF, 16'hFF, 1'b0);
        run_op(1, 16'h12, 16'h34, 1'b0);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("hold_product", 64'(prod_of(1)), 64'h3A8);
            chk("hold_done", 64'(done_of(1)), 64'd0);
        end
        run_op(1, 16'h12, 16'h34, 1'b1);

        // start held high: one done every 5 cycles, no idle gap
        @(negedge clk);
        a_s[1] = 16'd3; b_s[1] = 16'd5; start_s[1] = 1'b1;
        tick();
        for (int c = 0; c < 15; c++) begin
            chk("b2b_done", 64'(done_of(1)), 64'((c % 5) == 4));
            chk("b2b_busy", 64'(busy_of(1)), 64'((c % 5) != 4));
            if ((c % 5) == 4) chk("b2b_product", 64'(prod_of(1)), 64'hF);
            if (c == 14) start_s[1] = 1'b0;
            tick();
        end

        // reset during the second RUN cycle aborts without a done
        @(negedge clk);
        a_s[1] = 16'h12; b_s[1] = 16'h34; start_s[1] = 1'b1;
        tick();
        start_s[1] = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("abort_busy", 64'(busy_of(1)), 64'd0);
        chk("abort_done", 64'(done_of(1)), 64'd0);
        chk("abort_product", 64'(prod_of(1)), 64'd0);
        chk("abort_mul", 64'({mm_of(1), mq_of(1)}), 64'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("abort_no_done", 64'(done_of(1)), 64'd0);
            chk("abort_idle", 64'(busy_of(1)), 64'd0);
        end
        run_op(1, 16'h12, 16'h34, 1'b0);

        run_op(0, 16'hF, 16'hF, 1'b0);
        run_op(2, 16'hFFFF, 16'hFFFF, 1'b0);

        for (int k = 0; k < 3; k++) begin
            for (int t = 0; t < 1000; t++) begin
                run_op(k, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
